// File: rtl/ps2_host.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host
// Purpose  : Host-side PS/2 controller. Receives device-to-host frames and
//            sends host-to-device command bytes (inhibit, request-to-send,
//            device-clocked shift-out, ACK check). Both pad lines are
//            open-drain: driven 0 or released, never driven 1.
// Ports    : clk, rst_n          - system clock, async active-low reset
//            tx_data/tx_valid    - command byte and send request
//            tx_ready            - high only while idle
//            tx_done/tx_err      - one-cycle send result pulses
//            rx_data/rx_valid    - last good received byte and update pulse
//            rx_err              - one-cycle receive error pulse
//            ps2_clk/ps2_data    - open-drain pad lines (external pull-ups)
// Revision : 1.0 - initial release
// ============================================================================
module ps2_host #(
  parameter int INHIBIT_CYCLES = 5000,      // must be >= 2
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  inout  wire        ps2_clk,
  inout  wire        ps2_data
);

  localparam int FCW = $clog2(FILTER_LEN) + 1;
  localparam int IW  = $clog2(INHIBIT_CYCLES) + 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_RX           = 3'd1,
    S_TX_INHIBIT   = 3'd2,
    S_TX_RTS       = 3'd3,
    S_TX_BITS      = 3'd4,
    S_TX_ACK       = 3'd5,
    S_TX_WAIT_IDLE = 3'd6
  } state_e;

  // Index 0 = clock line, index 1 = data line.
  logic [1:0]          sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]          filt_q, filt_d;
  logic [1:0][FCW-1:0] fcnt_q, fcnt_d;
  logic                clk_prev_q, clk_prev_d;

  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [8:0]  rx_sr_q, rx_sr_d;
  logic [8:0]  tx_sr_q, tx_sr_d;
  logic [IW-1:0] inh_cnt_q, inh_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic        clk_oe_q, clk_oe_d;
  logic        data_oe_q, data_oe_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_err_q, rx_err_d;
  logic        tx_done_q, tx_done_d;
  logic        tx_err_q, tx_err_d;

  logic w_fall, w_data, w_timed, w_timeout;

  assign ps2_clk  = clk_oe_q  ? 1'b0 : 1'bz;
  assign ps2_data = data_oe_q ? 1'b0 : 1'bz;

  assign tx_ready = (state_q == S_IDLE);
  assign tx_done  = tx_done_q;
  assign tx_err   = tx_err_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;

  // Synchronizer plus run-length filter: a line only changes its filtered
  // value after FILTER_LEN consecutive opposite samples.
  always_comb begin
    sync1_d    = {ps2_data, ps2_clk};
    sync2_d    = sync1_q;
    clk_prev_d = filt_q[0];
    filt_d     = filt_q;
    fcnt_d     = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FCW'(FILTER_LEN - 1)) begin
          filt_d[i] = sync2_q[i];
        end else begin
          fcnt_d[i] = fcnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign w_fall  = clk_prev_q & ~filt_q[0];
  assign w_data  = filt_q[1];
  assign w_timed = (state_q == S_RX) || (state_q == S_TX_RTS) ||
                   (state_q == S_TX_BITS) || (state_q == S_TX_ACK) ||
                   (state_q == S_TX_WAIT_IDLE);
  assign w_timeout = w_timed && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_sr_d    = rx_sr_q;
    tx_sr_d    = tx_sr_q;
    inh_cnt_d  = inh_cnt_q;
    clk_oe_d   = clk_oe_q;
    data_oe_d  = data_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    tx_done_d  = 1'b0;
    tx_err_d   = 1'b0;
    // Watchdog runs only while waiting on the device; any clock edge rearms it.
    to_cnt_d   = (w_timed && !w_fall) ? to_cnt_q + 1'b1 : '0;

    if (w_timeout) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      bit_cnt_d = '0;
      state_d   = S_IDLE;
      if (state_q == S_RX) rx_err_d = 1'b1;
      else                 tx_err_d = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // A send request beats a simultaneous device start edge.
          if (tx_valid) begin
            tx_sr_d   = {~^tx_data, tx_data};
            clk_oe_d  = 1'b1;
            inh_cnt_d = '0;
            state_d   = S_TX_INHIBIT;
          end else if (w_fall) begin
            if (!w_data) begin
              bit_cnt_d = 4'd1;
              state_d   = S_RX;
            end else begin
              rx_err_d = 1'b1;
            end
          end
        end

        S_RX: begin
          if (w_fall) begin
            if (bit_cnt_q == 4'd10) begin
              // rx_sr holds d0..d7 in [7:0], parity in [8]; frame is odd.
              if (w_data && (^rx_sr_q)) begin
                rx_data_d  = rx_sr_q[7:0];
                rx_valid_d = 1'b1;
              end else begin
                rx_err_d = 1'b1;
              end
              bit_cnt_d = '0;
              state_d   = S_IDLE;
            end else begin
              rx_sr_d   = {w_data, rx_sr_q[8:1]};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        S_TX_INHIBIT: begin
          inh_cnt_d = inh_cnt_q + 1'b1;
          // Start bit goes low during the final inhibit cycle.
          if (inh_cnt_q == IW'(INHIBIT_CYCLES - 2)) data_oe_d = 1'b1;
          if (inh_cnt_q == IW'(INHIBIT_CYCLES - 1)) begin
            clk_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = S_TX_RTS;
          end
        end

        S_TX_RTS, S_TX_BITS: begin
          // Edges 1..9 present d0..d7 then parity; edge 10 releases for stop.
          if (w_fall) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q <= 4'd8) begin
              data_oe_d = ~tx_sr_q[0];
              tx_sr_d   = {1'b0, tx_sr_q[8:1]};
              state_d   = S_TX_BITS;
            end else begin
              data_oe_d = 1'b0;
              state_d   = S_TX_ACK;
            end
          end
        end

        S_TX_ACK: begin
          if (w_fall) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (!w_data) tx_done_d = 1'b1;
            else         tx_err_d  = 1'b1;
            state_d = S_TX_WAIT_IDLE;
          end
        end

        S_TX_WAIT_IDLE: begin
          if (filt_q[0] && filt_q[1]) begin
            bit_cnt_d = '0;
            state_d   = S_IDLE;
          end
        end

        default: begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          bit_cnt_d = '0;
          state_d   = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      filt_q     <= 2'b11;
      fcnt_q     <= '0;
      clk_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      rx_sr_q    <= '0;
      tx_sr_q    <= '0;
      inh_cnt_q  <= '0;
      to_cnt_q   <= '0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_err_q   <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      clk_prev_q <= clk_prev_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_sr_q    <= rx_sr_d;
      tx_sr_q    <= tx_sr_d;
      inh_cnt_q  <= inh_cnt_d;
      to_cnt_q   <= to_cnt_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
      tx_done_q  <= tx_done_d;
      tx_err_q   <= tx_err_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/ps2_host.md
# ps2_host

Synthesizable host-side PS/2 controller; the FPGA end of the link driven by the `Mouse` device model in the PS/2 simulation bench. Receives device-to-host frames and sends host-to-device command bytes (request-to-send, device-clocked shift-out, ACK check). Game logic sits on the byte interface; `ps2_clk`/`ps2_data` connect to the pads with external pull-ups.

## Interface
- `INHIBIT_CYCLES`, 5000: `clk` cycles `ps2_clk` is held low before a send (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, 1_000_000: max `clk` cycles between expected PS/2 events before abort (20 ms at 50 MHz).
- `FILTER_LEN`, 8: consecutive equal synchronized samples needed to change a filtered line value.
- `clk` in 1: system clock (one clock domain).
- `rst_n` in 1: asynchronous, active-low reset.
- `tx_data` in 8: command byte to send.
- `tx_valid` in 1: send request; accepted when `tx_valid && tx_ready`.
- `tx_ready` out 1: high only in IDLE.
- `tx_done` out 1: one-cycle pulse, device ACK received.
- `tx_err` out 1: one-cycle pulse, send aborted (timeout or no ACK).
- `rx_data` out 8: last good received byte; holds until next good frame.
- `rx_valid` out 1: one-cycle pulse, `rx_data` updated.
- `rx_err` out 1: one-cycle pulse, bad start/parity/stop or RX timeout.
- `ps2_clk` inout 1: open-drain; driven 0 or released (z), never driven 1.
- `ps2_data` inout 1: open-drain; as above.

## Operation
- Input conditioning: each line → 2-FF synchronizer → filter (reset value 1). Falling edge = filtered `ps2_clk` 1→0; all PS/2 events use it.
- States: IDLE, RX, TX_INHIBIT, TX_RTS, TX_BITS, TX_ACK, TX_WAIT_IDLE.
- IDLE: both lines released. Accepted send → TX_INHIBIT (latch byte, parity = ~^tx_data). Else falling edge → RX, sample start bit. Send request and falling edge on the same cycle: send wins, frame discarded, no `rx_err`.
- RX: sample `ps2_data` on each of 11 falling edges: start(0), d0..d7 LSB-first, odd parity, stop(1). Start=1 → `rx_err`, IDLE immediately. After stop: all good → `rx_data`, `rx_valid`; else `rx_err` only, `rx_data` unchanged. Return IDLE.
- TX_INHIBIT: drive `ps2_clk`=0 for INHIBIT_CYCLES; drive `ps2_data`=0 in last cycle. → TX_RTS.
- TX_RTS: release `ps2_clk`, keep `ps2_data`=0 (start bit). Falling edge k=1..8 → drive d(k-1) (0 driven, 1 released); k=9 → parity; k=10 → release (stop). Counting continues in TX_BITS after edge 1.
- TX_ACK: 11th falling edge: sampled `ps2_data`=0 → `tx_done`; 1 → `tx_err`. → TX_WAIT_IDLE.
- TX_WAIT_IDLE: wait filtered clk=1 and data=1 → IDLE. Device reply (e.g. 0xFA) then arrives as a normal RX frame.
- Timeout: counter cleared on entering RX/TX_RTS/TX_BITS/TX_ACK/TX_WAIT_IDLE and on every falling edge; reaching TIMEOUT_CYCLES releases both lines, pulses `rx_err` (RX) or `tx_err` (TX states), → IDLE.
- Bit counter 4 bits, only values 0..11 reachable.

## Timing
- Reset (async, immediate): lines released, state IDLE, filters 1, `rx_data`=0x00, all pulses 0; `tx_ready`=1 first cycle after `rst_n` rises. Reset mid-send releases `ps2_clk` within the same cycle (no clock edge needed).
- Edge-detect latency: 2 + FILTER_LEN cycles from pad transition to internal falling-edge event.
- `rx_valid`/`rx_err` assert the cycle after the 11th falling edge event; `tx_done`/`tx_err` the cycle after the ACK sample.
- `tx_ready` drops the cycle after acceptance; `ps2_clk` driven low that same cycle (registered output).
- Host data changes only after a falling-edge event (device clock low), so data is stable before the device's rising-edge sample.
- `tx_data` sampled only at acceptance.

## Test plan
- Reset: assert `rst_n` low in TX_INHIBIT → both lines z same cycle, no pulses, `tx_ready`=1 after release.
- RX good: device frame start 0, bits 1,1,0,1,0,0,1,0, parity 1, stop 1 at 10 kHz → `rx_data`=0x4B, one `rx_valid`, no `rx_err`.
- RX parity error: same frame, parity 0 → one `rx_err`, no `rx_valid`, `rx_data` keeps 0x4B.
- TX with device model: send 0xF4 → clk low ≥ INHIBIT_CYCLES, start 0, data bits 0,0,1,0,1,1,1,1, parity 0, stop released, device ACK → one `tx_done`, then reply 0xFA → `rx_valid`, `rx_data`=0xFA.
- TX no device (never clocks after RTS) → `tx_err` at TIMEOUT_CYCLES, lines released, `tx_ready`=1.
- Collision: `tx_valid` on the cycle of a device start-bit falling edge → send proceeds, `ps2_clk` pulled low, no `rx_valid`/`rx_err`.
